// File: rtl/load_unit_pkg.sv
// rtl/load_unit_pkg.sv - load unit shared types, extender selects, error codes
package load_unit_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [2:0] SE_SEXT16 = 3'b000;
  localparam logic [2:0] SE_ZEXT16 = 3'b001;
  localparam logic [2:0] SE_LUI    = 3'b010;
  localparam logic [2:0] SE_SEXT8  = 3'b011;
  localparam logic [2:0] SE_ZEXT8  = 3'b100;

  localparam logic [1:0] WB_ERR_OK       = 2'b00;
  localparam logic [1:0] WB_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] WB_ERR_TIMEOUT  = 2'b10;

  // Opcodes outside the enum behave as LW, so they need word alignment too.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      LH, LHU: is_misaligned = addr_lo[0];
      LB, LBU: is_misaligned = 1'b0;
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_lane_extract.sv
// rtl/load_lane_extract.sv - selects byte/halfword lane and drives the extender
module load_lane_extract
  import load_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [2:0]  se_select,
  output logic [15:0] se_in,
  output logic        is_word,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] se_out;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    se_select = SE_SEXT16;
    se_in     = lane_h;
    is_word   = 1'b0;
    case (op)
      LH:  se_select = SE_SEXT16;
      LHU: se_select = SE_ZEXT16;
      LB: begin
        se_select = SE_SEXT8;
        se_in     = {lane_b, lane_b};
      end
      LBU: begin
        se_select = SE_ZEXT8;
        se_in     = {8'h00, lane_b};
      end
      default: is_word = 1'b1;
    endcase
  end

  sign_extended u_sign_extended (
    .se_select (se_select),
    .se_in     (se_in),
    .se_out    (se_out)
  );

  assign data = is_word ? rdata : se_out;

endmodule

// File: rtl/sign_extended.sv
// rtl/sign_extended.sv - 16-bit to 32-bit sign/zero extender with LUI mode
module sign_extended
  import load_unit_pkg::*;
(
  input  logic [2:0]  se_select,
  input  logic [15:0] se_in,
  output logic [31:0] se_out
);

  // The 8-bit modes take their sign from bit 15, not bit 7.
  always_comb begin
    case (se_select)
      SE_SEXT16: se_out = {{16{se_in[15]}}, se_in};
      SE_ZEXT16: se_out = {16'h0000, se_in};
      SE_LUI:    se_out = {se_in, 16'h0000};
      SE_SEXT8:  se_out = {{24{se_in[15]}}, se_in[7:0]};
      SE_ZEXT8:  se_out = {24'h000000, se_in[7:0]};
      default:   se_out = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_unit_ctrl.sv
// rtl/load_unit_ctrl.sv - multicycle MEM-stage load controller with timeout
// LOAD_ALIGN_CHECK_EN enables misaligned-access rejection (wb_err=01).
module load_unit_ctrl
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RD_W           = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [2:0]      ld_op,
  input  logic [31:0]     ld_addr,
  input  logic [RD_W-1:0] ld_rd,
  output logic            mem_req,
  output logic [31:0]     mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic [1:0]      wb_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [1:0]      wb_err_q, wb_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            misaligned;
  logic [2:0]      se_select;
  logic [15:0]     se_in;
  logic            is_word;
  logic [31:0]     ext_data;
  logic            unused_ext;

  load_lane_extract u_extract (
    .op        (op_q),
    .addr_lo   (addr_lo_q),
    .rdata     (mem_rdata),
    .se_select (se_select),
    .se_in     (se_in),
    .is_word   (is_word),
    .data      (ext_data)
  );

  assign unused_ext = ^{se_select, se_in, is_word};

`ifdef LOAD_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(ld_op, ld_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_lo_d  = addr_lo_q;
    mem_addr_d = mem_addr_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_err_d   = wb_err_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          op_d       = ld_op;
          addr_lo_d  = ld_addr[1:0];
          mem_addr_d = {ld_addr[31:2], 2'b00};
          wb_rd_d    = ld_rd;
          cnt_d      = '0;
          if (misaligned) begin
            wb_data_d = 32'h0;
            wb_err_d  = WB_ERR_MISALIGN;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CW'(1);
        // An expiring budget abandons the request even if granted now.
        if (cnt_q == TO_LAST) begin
          wb_data_d = 32'h0;
          wb_err_d  = WB_ERR_TIMEOUT;
          state_d   = ST_RESP;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          wb_data_d = ext_data;
          wb_err_d  = WB_ERR_OK;
          state_d   = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          wb_data_d = 32'h0;
          wb_err_d  = WB_ERR_TIMEOUT;
          state_d   = ST_RESP;
        end
      end
      default: begin
        if (wb_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'd0;
      addr_lo_q  <= 2'd0;
      mem_addr_q <= 32'h0;
      wb_data_q  <= 32'h0;
      wb_rd_q    <= '0;
      wb_err_q   <= WB_ERR_OK;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_lo_q  <= addr_lo_d;
      mem_addr_q <= mem_addr_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_err_q   <= wb_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ld_ready = (state_q == ST_IDLE);
  assign mem_req  = (state_q == ST_REQ);
  assign wb_valid = (state_q == ST_RESP);
  assign mem_addr = mem_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_err   = wb_err_q;

endmodule
